// File: rtl/burst_pulse_pkg.sv
// Shared types and defaults for the burst pulse generator.
// The pulse-count clamp lives here so the top and any bench use one rule.
package burst_pulse_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} bpg_state_e;

    localparam int unsigned DEF_MIN_PULSES = 3;
    localparam int unsigned DEF_MAX_PULSES = 5;
    localparam int unsigned DEF_CNT_W      = 3;
    localparam int unsigned DEF_GAP_W      = 4;

    function automatic int unsigned clamp_count(input int unsigned req,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (req < lo) begin
            return lo;
        end else if (req > hi) begin
            return hi;
        end
        return req;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the burst trigger.
// The history flop resets to 1 so a level already high at reset release is not an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic rise
);

    logic a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= 1'b1;
        end else begin
            a_q <= a;
        end
    end

    assign rise = a & ~a_q;

endmodule

// File: rtl/burst_pulse_gen.sv
// Burst pulse generator: a rising edge on a launches a clamped number of one-cycle
// b pulses separated by a programmable idle gap, followed by a one-cycle done.
module burst_pulse_gen
    import burst_pulse_pkg::*;
#(
    parameter int unsigned MIN_PULSES = DEF_MIN_PULSES,
    parameter int unsigned MAX_PULSES = DEF_MAX_PULSES,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned GAP_W      = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic [CNT_W-1:0] cnt_req,
    input  logic [GAP_W-1:0] gap,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             clamped,
    output logic             overrun
);

    if (MIN_PULSES < 1) begin : g_bad_min
        $error("MIN_PULSES must be at least 1");
    end
    if (MAX_PULSES < MIN_PULSES) begin : g_bad_max
        $error("MAX_PULSES must not be below MIN_PULSES");
    end
    if (MAX_PULSES >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow to hold MAX_PULSES");
    end

    logic             rise;
    bpg_state_e       state_q;
    logic [CNT_W-1:0] rem_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gcnt_q;
    logic [CNT_W-1:0] n_req;
    logic             req_clamped;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .rise  (rise)
    );

    always_comb begin
        n_req       = CNT_W'(clamp_count(32'(cnt_req), MIN_PULSES, MAX_PULSES));
        req_clamped = (32'(cnt_req) < MIN_PULSES) || (32'(cnt_req) > MAX_PULSES);
    end

    // Outputs are registered alongside the state so b is high exactly while in PULSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            clamped <= 1'b0;
            overrun <= 1'b0;
        end else begin
            b       <= 1'b0;
            done    <= 1'b0;
            clamped <= 1'b0;
            overrun <= rise && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= PULSE;
                        rem_q   <= n_req;
                        gap_q   <= gap;
                        b       <= 1'b1;
                        busy    <= 1'b1;
                        clamped <= req_clamped;
                    end
                end
                PULSE: begin
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else if (gap_q == '0) begin
                        b <= 1'b1;
                    end else begin
                        state_q <= GAP;
                        gcnt_q  <= gap_q;
                    end
                end
                GAP: begin
                    gcnt_q <= gcnt_q - GAP_W'(1);
                    if (gcnt_q == GAP_W'(1)) begin
                        state_q <= PULSE;
                        b       <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_pulse_gen.sv
// Directed and randomized bench for burst_pulse_gen against a timeline model
// that predicts each burst's pulse, busy and done cycles arithmetically.
module tb_burst_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0;
    logic [2:0] cnt_req = '0;
    logic [3:0] gap = '0;
    logic       b, busy, done, clamped, overrun;

    int checks = 0;
    int errors = 0;

    // Model: cycle index of the current burst's first pulse and of its done cycle.
    int  cyc = 0;
    int  bk = -100;
    int  bd = -100;
    int  bn = 0;
    int  bg = 0;
    bit  bcl = 0;
    bit  a_prev = 1;
    bit  exp_ov = 0;

    burst_pulse_gen u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .cnt_req (cnt_req),
        .gap     (gap),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .clamped (clamped),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".b"}, b, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, 1'b0);
        check({tag, ".clamped"}, clamped, 1'b0);
        check({tag, ".overrun"}, overrun, 1'b0);
    endtask

    task automatic step(input logic av, input logic [2:0] cv, input logic [3:0] gv);
        bit rise;
        int req;
        logic eb, ebusy, edone, ecl;
        @(negedge clk);
        a = av;
        cnt_req = cv;
        gap = gv;
        @(posedge clk);
        cyc++;
        rise = av && !a_prev;
        a_prev = av;
        exp_ov = 0;
        if (rise) begin
            if ((cyc - 1) >= bk && (cyc - 1) <= bd) begin
                exp_ov = 1;
            end else begin
                req = int'(cv);
                bn  = (req < 3) ? 3 : (req > 5) ? 5 : req;
                bcl = (req < 3) || (req > 5);
                bg  = int'(gv);
                bk  = cyc;
                bd  = bk + (bn - 1) * (bg + 1) + 1;
            end
        end
        eb    = (cyc >= bk) && (cyc < bd) && (((cyc - bk) % (bg + 1)) == 0);
        ebusy = (cyc >= bk) && (cyc <= bd);
        edone = (cyc == bd);
        ecl   = (cyc == bk) && bcl;
        #1;
        check("b", b, eb);
        check("busy", busy, ebusy);
        check("done", done, edone);
        check("clamped", clamped, ecl);
        check("overrun", overrun, exp_ov);
    endtask

    task automatic idle(input int n, input logic av);
        for (int i = 0; i < n; i++) begin
            step(av, 3'($urandom), 4'($urandom_range(0, 3)));
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
    task automatic async_reset(input logic av);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bk = -100;
        bd = -100;
        a_prev = 1;
        a = av;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: four pulses, one idle cycle between them, no clamp
        step(1'b0, 3'd4, 4'd1);
        step(1'b1, 3'd4, 4'd1);
        idle(10, 1'b1);
        idle(2, 1'b0);

        // 2: below-minimum back-to-back, then above-maximum
        step(1'b1, 3'd1, 4'd0);
        idle(5, 1'b1);
        step(1'b0, 3'd7, 4'd2);
        step(1'b1, 3'd7, 4'd2);
        idle(15, 1'b1);
        idle(2, 1'b0);

        // 3: retrigger during a gap, then exactly at the done cycle
        step(1'b1, 3'd5, 4'd2);
        step(1'b1, 3'd0, 4'd0);
        step(1'b0, 3'd0, 4'd0);
        step(1'b1, 3'd0, 4'd0);
        idle(9, 1'b1);
        step(1'b0, 3'd0, 4'd0);
        step(1'b1, 3'd3, 4'd0);
        idle(2, 1'b0);

        // 4: a high through reset release must not trigger
        step(1'b1, 3'd3, 4'd0);
        async_reset(1'b1);
        idle(4, 1'b1);
        step(1'b0, 3'd3, 4'd0);
        step(1'b1, 3'd3, 4'd0);
        idle(5, 1'b0);

        // 5: reset after the 2nd of 5 pulses, then a full fresh burst
        step(1'b1, 3'd5, 4'd1);
        idle(2, 1'b1);
        async_reset(1'b0);
        idle(2, 1'b0);
        step(1'b1, 3'd5, 4'd1);
        idle(12, 1'b0);

        // 6: randomized triggers, gaps and counts
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0) ? ~a : a,
                 3'($urandom), 4'($urandom_range(0, 3)));
        end
        idle(20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
